// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulator sequencer.
package acc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_EXEC,
        S_WAIT_ALU,
        S_WRITE,
        S_REPORT
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR
    } op_t;

    localparam logic [7:0] ASCII_BASE = 8'h30;

    function automatic logic [7:0] ascii_digit(input logic [1:0] v);
        return ASCII_BASE + {6'b0, v};
    endfunction

endpackage

// File: rtl/acc_op_sequencer_stable_detector.sv
// Flags when a 2-bit value has held for N consecutive cycles, counting from a clear
// or from the most recent change (the cycle of the change counts as the first).
module stable_detector #(
    parameter int N = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] value,
    output logic       stable
);
    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0] run_q, run_d;
    logic [1:0]    prev_q;
    logic          fresh_q;

    // The current cycle's run length: zero right after a clear or on any change.
    always_comb begin
        if (fresh_q || (value != prev_q)) begin
            run_d = '0;
        end else if (run_q == CW'(N - 1)) begin
            run_d = run_q;
        end else begin
            run_d = run_q + CW'(1);
        end
        stable = (run_d == CW'(N - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q   <= '0;
            prev_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            prev_q  <= value;
            fresh_q <= clear;
        end
    end

endmodule

// File: rtl/acc_op_sequencer.sv
// Arbitrates UART loads and confirmed ALU operations on the 2-bit accumulator,
// drives the ALU start/done handshake and reports each result as an ASCII digit.
module acc_op_sequencer
    import acc_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = 50000,
    parameter int ALU_TIMEOUT   = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       confirm_pulse,
    input  logic       handshake_en,
    input  logic [1:0] operation,
    input  logic [1:0] finger_value,
    output logic       alu_start,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_op,
    input  logic       alu_done,
    input  logic [1:0] alu_result,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] acc,
    output logic       busy,
    output logic       alu_error
);
    localparam int TW = $clog2(ALU_TIMEOUT) + 1;

    state_t        state_q, state_d;
    logic [1:0]    acc_q, acc_d;
    logic          pend_vld_q, pend_vld_d;
    logic [1:0]    pend_q, pend_d;
    op_t           op_q, op_d;
    logic [1:0]    b_q, b_d;
    logic [1:0]    res_q, res_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          alu_start_q, alu_start_d;
    logic [1:0]    alu_a_q, alu_a_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic accept;
    logic stable;
    logic unused_rx;

    assign unused_rx = ^rx_data[7:2];
    assign accept    = (state_q == S_IDLE) && confirm_pulse && handshake_en;

    stable_detector #(.N(STABLE_CYCLES)) u_stable (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .value  (finger_value),
        .stable (stable)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
        op_d        = op_q;
        b_d         = b_q;
        res_d       = res_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        alu_start_d = 1'b0;
        alu_a_d     = alu_a_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = op_t'(operation);
                    err_d   = 1'b0;
                    state_d = S_SETTLE;
                end else if (rx_valid) begin
                    acc_d      = rx_data[1:0];
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    acc_d      = pend_q;
                    pend_vld_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (!handshake_en) begin
                    state_d = S_IDLE;
                end else if (stable) begin
                    b_d         = finger_value;
                    alu_a_d     = acc_q;
                    alu_start_d = 1'b1;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                tmo_d   = '0;
                state_d = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                if (alu_done) begin
                    res_d   = alu_result;
                    state_d = S_WRITE;
                end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: begin
                acc_d      = res_q;
                tx_valid_d = 1'b1;
                tx_data_d  = ascii_digit(res_q);
                state_d    = S_REPORT;
            end
            S_REPORT: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bytes that cannot be applied right now park in the one-deep slot; newest wins.
        if (rx_valid && ((state_q != S_IDLE) || accept)) begin
            pend_d     = rx_data[1:0];
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            op_q        <= OP_ADD;
            b_q         <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            alu_start_q <= 1'b0;
            alu_a_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            b_q         <= b_d;
            res_q       <= res_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            alu_start_q <= alu_start_d;
            alu_a_q     <= alu_a_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign alu_start = alu_start_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign acc       = acc_q;
    assign busy      = (state_q != S_IDLE);
    assign alu_error = err_q;

endmodule

// File: tb/tb_acc_op_sequencer.sv
// Bench for acc_op_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a timestamp-based reference model.
module tb_acc_op_sequencer;
    localparam int S  = 8;
    localparam int TO = 12;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_EXEC   = 2;
    localparam int M_WAIT   = 3;
    localparam int M_WRITE  = 4;
    localparam int M_REPORT = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       confirm_pulse = 1'b0;
    logic       handshake_en = 1'b1;
    logic [1:0] operation = 2'd0;
    logic [1:0] finger_value = 2'd0;
    logic       alu_start;
    logic [1:0] alu_a, alu_b, alu_op;
    logic       alu_done = 1'b0;
    logic [1:0] alu_result = 2'd0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic [1:0] acc;
    logic       busy, alu_error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // External ALU responder state
    int         alu_delay = 3;
    int         alu_cnt = 0;
    logic [1:0] alu_res_hold = 2'd0;

    // Reference model state
    int         ph = M_IDLE;
    int         m_acc = 0, m_pend = -1, m_err = 0, m_res = 0;
    int         settle_first = 0, since = 0, wait_first = 0;
    int         prev_f = 0;
    int         e_start = 0, e_a = 0, e_b = 0, e_op = 0, e_txv = 0, e_txd = 0;

    acc_op_sequencer #(.STABLE_CYCLES(S), .ALU_TIMEOUT(TO)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .confirm_pulse (confirm_pulse),
        .handshake_en  (handshake_en),
        .operation     (operation),
        .finger_value  (finger_value),
        .alu_start     (alu_start),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_done      (alu_done),
        .alu_result    (alu_result),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .acc           (acc),
        .busy          (busy),
        .alu_error     (alu_error)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] alu_fn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advances expected state using the inputs of the cycle that just ended.
    task automatic model_step();
        int p;
        int was;
        p   = cyc;
        was = ph;
        if (reset) begin
            ph = M_IDLE; m_acc = 0; m_pend = -1; m_err = 0;
            e_start = 0; e_a = 0; e_b = 0; e_op = 0; e_txv = 0; e_txd = 0;
        end else begin
            e_start = 0;
            case (ph)
                M_IDLE: begin
                    if (confirm_pulse && handshake_en) begin
                        e_op = operation; m_err = 0; ph = M_SETTLE; settle_first = p + 1;
                    end else if (rx_valid) begin
                        m_acc = rx_data[1:0]; m_pend = -1;
                    end else if (m_pend >= 0) begin
                        m_acc = m_pend; m_pend = -1;
                    end
                    if (ph == M_SETTLE && rx_valid) m_pend = rx_data[1:0];
                end
                M_SETTLE: begin
                    if (!handshake_en) begin
                        ph = M_IDLE;
                    end else begin
                        if (p == settle_first || int'(finger_value) != prev_f) since = p;
                        if (p - since + 1 == S) begin
                            ph = M_EXEC; e_start = 1; e_a = m_acc; e_b = finger_value;
                        end
                    end
                end
                M_EXEC: begin
                    ph = M_WAIT; wait_first = p + 1;
                end
                M_WAIT: begin
                    if (alu_done) begin
                        m_res = alu_result; ph = M_WRITE;
                    end else if (p - wait_first + 1 == TO) begin
                        m_err = 1; ph = M_IDLE;
                    end
                end
                M_WRITE: begin
                    m_acc = m_res; e_txv = 1; e_txd = 8'h30 + m_res; ph = M_REPORT;
                end
                default: begin
                    if (tx_ready) begin
                        e_txv = 0; ph = M_IDLE;
                    end
                end
            endcase
            if (was != M_IDLE && rx_valid) m_pend = rx_data[1:0];
        end
        prev_f = finger_value;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
            cyc++;
            @(negedge clock);
            chk("acc", acc, m_acc);
            chk("busy", busy, ph != M_IDLE);
            chk("alu_start", alu_start, e_start);
            chk("alu_a", alu_a, e_a);
            chk("alu_b", alu_b, e_b);
            chk("alu_op", alu_op, e_op);
            chk("tx_valid", tx_valid, e_txv);
            chk("tx_data", tx_data, e_txd);
            chk("alu_error", alu_error, m_err);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        alu_done = 1'b0;
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                alu_done   = 1'b1;
                alu_result = alu_res_hold;
            end
        end
        if (alu_start && alu_delay > 0) begin
            alu_cnt      = alu_delay;
            alu_res_hold = alu_fn(alu_a, alu_b, alu_op);
        end
    endtask

    // which: 0 alu_start, 1 tx_valid, 2 not busy
    task automatic wait_cond(input int which, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc && at < 0; i++) begin
            step();
            case (which)
                0:       if (alu_start) at = cyc;
                1:       if (tx_valid) at = cyc;
                default: if (!busy) at = cyc;
            endcase
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_%0d: no event within %0d cycles", which, maxc);
        end
    endtask

    task automatic confirm(input logic [1:0] op, input logic [1:0] f, output int t);
        operation     = op;
        finger_value  = f;
        confirm_pulse = 1'b1;
        t = cyc;
        step();
        confirm_pulse = 1'b0;
    endtask

    initial begin
        int t, e, at, c, starts;

        // Reset and load
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_acc", acc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx", {tx_valid, tx_data}, 0);
        chk("rst_alu", {alu_start, alu_a, alu_b, alu_op, alu_error}, 0);
        rx_valid = 1'b1; rx_data = 8'h02;
        step();
        rx_valid = 1'b0;
        chk("load_acc", acc, 2);
        chk("load_busy", busy, 0);
        chk("load_txv", tx_valid, 0);

        // Add 2+3 with a stalled transmitter
        tx_ready = 1'b0;
        confirm(2'd0, 2'd3, t);
        wait_cond(0, S + 5, e);
        chk("add_launch_cycle", e, t + 1 + S);
        chk("add_operands", {alu_a, alu_b, alu_op}, {2'd2, 2'd3, 2'd0});
        wait_cond(1, 10, at);
        chk("add_report_cycle", at, e + 5);
        chk("add_acc", acc, 1);
        for (int i = 0; i < 5; i++) begin
            chk("add_tx_hold", {tx_valid, tx_data}, {1'b1, 8'h31});
            step();
        end
        tx_ready = 1'b1;
        step();
        chk("add_idle", {busy, tx_valid}, 0);

        // Finger bounce restarts the settle window
        confirm(2'd2, 2'd1, t);
        step(); step();
        finger_value = 2'd2;
        c = cyc;
        wait_cond(0, S + 5, e);
        chk("bounce_launch_cycle", e, c + S);
        chk("bounce_b", alu_b, 2);
        wait_cond(2, 20, at);
        chk("bounce_acc", acc, 0);

        // Confirm with simultaneous rx; later rx during WAIT_ALU overwrites the slot
        rx_valid = 1'b1; rx_data = 8'h03;
        confirm(2'd0, 2'd2, t);
        rx_valid = 1'b0;
        wait_cond(0, S + 5, e);
        chk("sim_old_acc", alu_a, 0);
        step();
        rx_valid = 1'b1; rx_data = 8'h01;
        step();
        rx_valid = 1'b0;
        wait_cond(1, 10, at);
        chk("sim_result", acc, 2);
        step();
        chk("sim_idle", busy, 0);
        step();
        chk("sim_pend_drain", acc, 1);

        // ALU never answers
        alu_delay = 0;
        confirm(2'd0, 2'd1, t);
        wait_cond(0, S + 5, e);
        repeat (TO) step();
        chk("to_before", {busy, alu_error}, {1'b1, 1'b0});
        step();
        chk("to_after", {busy, alu_error, acc}, {1'b0, 1'b1, 2'd1});
        alu_delay = 3;
        confirm(2'd1, 2'd3, t);
        chk("to_clear", alu_error, 0);
        wait_cond(2, S + 20, at);
        chk("sub_acc", acc, 2);

        // Handshake gating and SETTLE abort
        handshake_en = 1'b0;
        confirm(2'd0, 2'd1, t);
        chk("gate_ignored", busy, 0);
        handshake_en = 1'b1;
        confirm(2'd0, 2'd1, t);
        chk("gate_settle", busy, 1);
        step();
        handshake_en = 1'b0;
        step();
        handshake_en = 1'b1;
        chk("abort_idle", busy, 0);
        starts = 0;
        for (int i = 0; i < S + 3; i++) begin
            step();
            if (alu_start) starts++;
        end
        chk("abort_no_start", starts, 0);

        // Reset while reporting
        tx_ready = 1'b0;
        confirm(2'd3, 2'd1, t);
        wait_cond(1, S + 20, at);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tx_ready = 1'b1;
        chk("rst_report", {tx_valid, acc, busy}, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rx_valid      = ($urandom_range(0, 9) == 0);
            rx_data       = 8'($urandom);
            confirm_pulse = ($urandom_range(0, 19) == 0);
            handshake_en  = ($urandom_range(0, 49) != 0);
            operation     = 2'($urandom);
            if ($urandom_range(0, 11) == 0) finger_value = 2'($urandom);
            tx_ready      = ($urandom_range(0, 2) != 0);
            reset         = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0) alu_delay = $urandom_range(0, TO + 3);
            step();
        end
        reset = 1'b0; rx_valid = 1'b0; confirm_pulse = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
